// File: rtl/axi_sim_pkg.sv
// Shared definitions for the simulated AXI memory: response codes, FSM state
// encodings and the response-severity merge used by the write path.
package axi_sim_pkg;

    // AXI response codes; numeric order matches severity for the codes used here
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DATA
    } rd_state_t;

    // Worst of two responses: DECERR > SLVERR > OKAY
    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_sim_ram.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read port.
// Each byte lane is its own array so lane-wise writes infer cleanly; a read and
// a write to the same word in one cycle return the old contents.
module axi_sim_ram
    import axi_sim_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4096
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [DATA_W/8-1:0]    wstrb,
    input  logic                   re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]      rdata
);

    localparam int NB = DATA_W / 8;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            // Contents start at zero and are never touched by reset
            logic [7:0] lane_mem [DEPTH] = '{default: 8'h00};
            logic [7:0] q_reg;

            // Byte-lane write, gated by its strobe
            always_ff @(posedge clock) begin
                if (we && wstrb[gi]) begin
                    lane_mem[waddr] <= wdata[gi*8 +: 8];
                end
            end

            // Registered read; holds its value when no read is issued
            always_ff @(posedge clock) begin
                if (reset) begin
                    q_reg <= 8'h00;
                end else if (re) begin
                    q_reg <= lane_mem[raddr];
                end
            end

            assign rdata[gi*8 +: 8] = q_reg;
        end
    endgenerate

endmodule

// File: rtl/axi_sim_mem.sv
// AXI slave memory model for simulation/FPGA test harnesses. Independent write
// and read engines, each with one outstanding INCR burst of full-width beats.
// Out-of-range beats answer DECERR; a wlast that disagrees with awlen yields
// SLVERR while the burst length still follows awlen.
module axi_sim_mem
    import axi_sim_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 4096
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                axi_awvalid,
    output logic                axi_awready,
    input  logic [ID_W-1:0]     axi_awid,
    input  logic [31:0]         axi_awaddr,
    input  logic [7:0]          axi_awlen,
    input  logic                axi_wvalid,
    output logic                axi_wready,
    input  logic [DATA_W-1:0]   axi_wdata,
    input  logic [DATA_W/8-1:0] axi_wstrb,
    input  logic                axi_wlast,
    output logic                axi_bvalid,
    input  logic                axi_bready,
    output logic [ID_W-1:0]     axi_bid,
    output logic [1:0]          axi_bresp,
    input  logic                axi_arvalid,
    output logic                axi_arready,
    input  logic [ID_W-1:0]     axi_arid,
    input  logic [31:0]         axi_araddr,
    input  logic [7:0]          axi_arlen,
    output logic                axi_rvalid,
    input  logic                axi_rready,
    output logic [ID_W-1:0]     axi_rid,
    output logic [DATA_W-1:0]   axi_rdata,
    output logic [1:0]          axi_rresp,
    output logic                axi_rlast
);

    localparam int          SHIFT   = $clog2(DATA_W / 8);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    // ---------------- write engine state ----------------
    wr_state_t         wr_state_reg;
    logic [ID_W-1:0]   wr_id_reg;
    logic [31:0]       wr_word_reg;     // word index of the current beat
    logic [7:0]        wr_len_reg;
    logic [7:0]        wr_cnt_reg;
    logic [1:0]        wr_resp_reg;     // worst response so far in this burst
    logic              awready_reg;
    logic              wready_reg;
    logic              bvalid_reg;
    logic [ID_W-1:0]   bid_reg;
    logic [1:0]        bresp_reg;

    logic              wr_beat;
    logic              wr_oob;
    logic              wr_last;
    logic [1:0]        wr_beat_resp;
    logic [1:0]        wr_resp_next;
    logic              ram_we;

    // ---------------- read engine state ----------------
    rd_state_t         rd_state_reg;
    logic [ID_W-1:0]   rd_id_reg;
    logic [31:0]       rd_word_reg;
    logic [7:0]        rd_len_reg;
    logic [7:0]        rd_cnt_reg;
    logic              arready_reg;
    logic              rvalid_reg;
    logic [ID_W-1:0]   rid_reg;
    logic [1:0]        rresp_reg;
    logic              rlast_reg;
    logic              rd_zero_reg;     // current beat is out of range: force zero data
    logic              rd_oob;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    // Per-beat write qualification; the RAM write is suppressed on a reset edge
    // so an abandoned burst never commits the beat presented during reset.
    always_comb begin
        wr_beat      = wready_reg && axi_wvalid;
        wr_oob       = (wr_word_reg >= DEPTH_W);
        wr_last      = (wr_cnt_reg == wr_len_reg);
        wr_beat_resp = OKAY;
        if (wr_oob) begin
            wr_beat_resp = DECERR;
        end else if (axi_wlast != wr_last) begin
            wr_beat_resp = SLVERR;
        end
        wr_resp_next = worst_resp(wr_resp_reg, wr_beat_resp);
        ram_we       = wr_beat && !wr_oob && !reset;
    end

    // Write FSM: accept AW, absorb awlen+1 beats, then hold B until taken
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state_reg <= W_IDLE;
            wr_id_reg    <= '0;
            wr_word_reg  <= '0;
            wr_len_reg   <= '0;
            wr_cnt_reg   <= '0;
            wr_resp_reg  <= OKAY;
            awready_reg  <= 1'b0;
            wready_reg   <= 1'b0;
            bvalid_reg   <= 1'b0;
            bid_reg      <= '0;
            bresp_reg    <= OKAY;
        end else begin
            case (wr_state_reg)
                W_IDLE: begin
                    if (!awready_reg) begin
                        awready_reg <= 1'b1;
                    end else if (axi_awvalid) begin
                        awready_reg  <= 1'b0;
                        wready_reg   <= 1'b1;
                        wr_id_reg    <= axi_awid;
                        wr_word_reg  <= axi_awaddr >> SHIFT;
                        wr_len_reg   <= axi_awlen;
                        wr_cnt_reg   <= 8'd0;
                        wr_resp_reg  <= OKAY;
                        wr_state_reg <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wr_beat) begin
                        wr_resp_reg <= wr_resp_next;
                        wr_cnt_reg  <= wr_cnt_reg + 8'd1;
                        wr_word_reg <= wr_word_reg + 32'd1;
                        if (wr_last) begin
                            wready_reg   <= 1'b0;
                            bvalid_reg   <= 1'b1;
                            bid_reg      <= wr_id_reg;
                            bresp_reg    <= wr_resp_next;
                            wr_state_reg <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_bready) begin
                        bvalid_reg   <= 1'b0;
                        awready_reg  <= 1'b1;
                        wr_state_reg <= W_IDLE;
                    end
                end
                default: wr_state_reg <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_oob = (rd_word_reg >= DEPTH_W);
        ram_re = (rd_state_reg == R_FETCH);
    end

    // Read FSM: one registered fetch per beat, beat held until rready
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_state_reg <= R_IDLE;
            rd_id_reg    <= '0;
            rd_word_reg  <= '0;
            rd_len_reg   <= '0;
            rd_cnt_reg   <= '0;
            arready_reg  <= 1'b0;
            rvalid_reg   <= 1'b0;
            rid_reg      <= '0;
            rresp_reg    <= OKAY;
            rlast_reg    <= 1'b0;
            rd_zero_reg  <= 1'b0;
        end else begin
            case (rd_state_reg)
                R_IDLE: begin
                    if (!arready_reg) begin
                        arready_reg <= 1'b1;
                    end else if (axi_arvalid) begin
                        arready_reg  <= 1'b0;
                        rd_id_reg    <= axi_arid;
                        rd_word_reg  <= axi_araddr >> SHIFT;
                        rd_len_reg   <= axi_arlen;
                        rd_cnt_reg   <= 8'd0;
                        rd_state_reg <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    rvalid_reg   <= 1'b1;
                    rid_reg      <= rd_id_reg;
                    rresp_reg    <= rd_oob ? DECERR : OKAY;
                    rd_zero_reg  <= rd_oob;
                    rlast_reg    <= (rd_cnt_reg == rd_len_reg);
                    rd_state_reg <= R_DATA;
                end
                R_DATA: begin
                    if (axi_rready) begin
                        rvalid_reg <= 1'b0;
                        if (rlast_reg) begin
                            arready_reg  <= 1'b1;
                            rd_state_reg <= R_IDLE;
                        end else begin
                            rd_cnt_reg   <= rd_cnt_reg + 8'd1;
                            rd_word_reg  <= rd_word_reg + 32'd1;
                            rd_state_reg <= R_FETCH;
                        end
                    end
                end
                default: rd_state_reg <= R_IDLE;
            endcase
        end
    end

    axi_sim_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clock  (clock),
        .reset  (reset),
        .we     (ram_we),
        .waddr  (wr_word_reg[AW-1:0]),
        .wdata  (axi_wdata),
        .wstrb  (axi_wstrb),
        .re     (ram_re),
        .raddr  (rd_word_reg[AW-1:0]),
        .rdata  (ram_rdata)
    );

    assign axi_awready = awready_reg;
    assign axi_wready  = wready_reg;
    assign axi_bvalid  = bvalid_reg;
    assign axi_bid     = bid_reg;
    assign axi_bresp   = bresp_reg;
    assign axi_arready = arready_reg;
    assign axi_rvalid  = rvalid_reg;
    assign axi_rid     = rid_reg;
    assign axi_rdata   = rd_zero_reg ? '0 : ram_rdata;
    assign axi_rresp   = rresp_reg;
    assign axi_rlast   = rlast_reg;

endmodule

// File: tb/tb_axi_sim_mem.sv
// Self-checking bench for axi_sim_mem: a directed vector table, hand-written
// multi-cycle sequences and randomized bursts checked against an array model.
module tb_axi_sim_mem;

    localparam int DATA_W = 64;
    localparam int ID_W   = 4;
    localparam int DEPTH  = 4096;
    localparam int BUDGET = 200;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              axi_awvalid = 1'b0, axi_awready;
    logic [ID_W-1:0]   axi_awid = '0;
    logic [31:0]       axi_awaddr = '0;
    logic [7:0]        axi_awlen = '0;
    logic              axi_wvalid = 1'b0, axi_wready;
    logic [DATA_W-1:0] axi_wdata = '0;
    logic [7:0]        axi_wstrb = '0;
    logic              axi_wlast = 1'b0;
    logic              axi_bvalid, axi_bready = 1'b0;
    logic [ID_W-1:0]   axi_bid;
    logic [1:0]        axi_bresp;
    logic              axi_arvalid = 1'b0, axi_arready;
    logic [ID_W-1:0]   axi_arid = '0;
    logic [31:0]       axi_araddr = '0;
    logic [7:0]        axi_arlen = '0;
    logic              axi_rvalid, axi_rready = 1'b0;
    logic [ID_W-1:0]   axi_rid;
    logic [DATA_W-1:0] axi_rdata;
    logic [1:0]        axi_rresp;
    logic              axi_rlast;

    always #5 clock = ~clock;

    axi_sim_mem #(.DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bid(axi_bid), .axi_bresp(axi_bresp),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast)
    );

    int n_vec = 0;
    int n_mis = 0;

    // Reference memory: plain array of words, updated per the burst rules
    logic [63:0] mem_model [DEPTH];
    logic [63:0] wbuf_data [256];
    logic [7:0]  wbuf_strb [256];
    logic [63:0] rbuf_data [256];
    logic [1:0]  rbuf_resp [256];
    logic        rbuf_last [256];
    logic [3:0]  rbuf_id   [256];

    typedef struct {
        bit          wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  exp_resp;
        logic [63:0] exp_rdata;
    } vec_t;
    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string what);
        n_vec++;
        n_mis++;
        $display("FAIL %s: timed out after %0d cycles", what, BUDGET);
    endtask

    function automatic logic [63:0] model_read(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 3;
        if (w >= DEPTH) return 64'h0;
        return mem_model[w[11:0]];
    endfunction

    // Applies a burst from wbuf to the model and returns the expected bresp
    function automatic logic [1:0] model_write(input logic [31:0] addr, input int len, input bit bad);
        logic [1:0]  worst;
        logic [31:0] a;
        logic [31:0] w;
        worst = bad ? 2'b10 : 2'b00;
        for (int n = 0; n <= len; n++) begin
            a = addr + 32'(n * 8);
            w = a >> 3;
            if (w >= DEPTH) begin
                worst = 2'b11;
            end else begin
                for (int b = 0; b < 8; b++)
                    if (wbuf_strb[n][b]) mem_model[w[11:0]][b*8 +: 8] = wbuf_data[n][b*8 +: 8];
            end
        end
        return worst;
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input bit bad, input bit gaps,
                            output logic [3:0] got_bid, output logic [1:0] got_bresp);
        int t;
        @(negedge clock);
        axi_awvalid = 1'b1; axi_awid = id; axi_awaddr = addr; axi_awlen = len[7:0];
        t = 0;
        while (!axi_awready && t < BUDGET) begin @(negedge clock); t++; end
        if (t >= BUDGET) timeout_fail("aw handshake");
        @(negedge clock);
        axi_awvalid = 1'b0;
        for (int n = 0; n <= len; n++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clock);
            axi_wvalid = 1'b1; axi_wdata = wbuf_data[n]; axi_wstrb = wbuf_strb[n];
            axi_wlast  = (n == len) ^ (bad && n == 0);
            t = 0;
            while (!axi_wready && t < BUDGET) begin @(negedge clock); t++; end
            if (t >= BUDGET) timeout_fail("w beat");
            @(negedge clock);
            axi_wvalid = 1'b0; axi_wlast = 1'b0;
        end
        axi_bready = 1'b1;
        t = 0;
        while (!axi_bvalid && t < BUDGET) begin @(negedge clock); t++; end
        if (t >= BUDGET) timeout_fail("b response");
        got_bid = axi_bid; got_bresp = axi_bresp;
        @(negedge clock);
        axi_bready = 1'b0;
    endtask

    // mode 0: rready always high, 1: toggles every cycle, 2: random
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len, input int mode);
        int t;
        int n;
        bit stalled;
        logic [63:0] hd;
        logic [7:0]  hc;
        @(negedge clock);
        axi_arvalid = 1'b1; axi_arid = id; axi_araddr = addr; axi_arlen = len[7:0];
        t = 0;
        while (!axi_arready && t < BUDGET) begin @(negedge clock); t++; end
        if (t >= BUDGET) timeout_fail("ar handshake");
        @(negedge clock);
        axi_arvalid = 1'b0;
        n = 0; t = 0; stalled = 1'b0; hd = '0; hc = '0; axi_rready = 1'b0;
        while (n <= len && t < BUDGET) begin
            if (mode == 0)      axi_rready = 1'b1;
            else if (mode == 1) axi_rready = ~axi_rready;
            else                axi_rready = 1'($urandom_range(0, 1));
            if (stalled) begin
                chk("r_stable_data", axi_rdata, hd);
                chk("r_stable_ctrl", 64'({axi_rvalid, axi_rlast, axi_rresp, axi_rid}), 64'(hc));
            end
            if (axi_rvalid) begin
                if (axi_rready) begin
                    rbuf_data[n] = axi_rdata; rbuf_resp[n] = axi_rresp;
                    rbuf_last[n] = axi_rlast; rbuf_id[n] = axi_rid;
                    n++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hd = axi_rdata;
                    hc = {1'b1, axi_rlast, axi_rresp, axi_rid};
                end
            end else begin
                stalled = 1'b0;
            end
            @(negedge clock);
            t++;
        end
        if (n <= len) timeout_fail("r beats");
        axi_rready = 1'b0;
    endtask

    task automatic run_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input bit bad, input bit gaps);
        logic [3:0] gid;
        logic [1:0] gresp;
        logic [1:0] eresp;
        do_write(id, addr, len, bad, gaps, gid, gresp);
        eresp = model_write(addr, len, bad);
        chk("bid", 64'(gid), 64'(id));
        chk("bresp", 64'(gresp), 64'(eresp));
        $display("write id=%0h addr=%08h len=%0d badlast=%0d bresp=%0d", id, addr, len, bad, gresp);
    endtask

    task automatic run_read(input logic [3:0] id, input logic [31:0] addr, input int len, input int mode);
        logic [31:0] a;
        do_read(id, addr, len, mode);
        for (int n = 0; n <= len; n++) begin
            a = addr + 32'(n * 8);
            chk($sformatf("rdata[%0d]", n), rbuf_data[n], model_read(a));
            chk($sformatf("rresp[%0d]", n), 64'(rbuf_resp[n]), ((a >> 3) >= DEPTH) ? 64'd3 : 64'd0);
            chk($sformatf("rlast[%0d]", n), 64'(rbuf_last[n]), 64'(n == len));
            chk($sformatf("rid[%0d]", n), 64'(rbuf_id[n]), 64'(id));
        end
        $display("read  id=%0h addr=%08h len=%0d mode=%0d rresp0=%0d", id, addr, len, mode, rbuf_resp[0]);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, 64'({axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rlast}), 64'd0);
        chk({tag, "_ids"}, 64'({axi_bid, axi_bresp, axi_rid, axi_rresp}), 64'd0);
        chk({tag, "_rdata"}, axi_rdata, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] gid_w;
        logic [1:0] gresp_w;
        logic [1:0] eresp;
        int t;
        bit seen;

        for (int i = 0; i < DEPTH; i++) mem_model[i] = 64'h0;

        vecs[0] = '{1'b1, 4'h1, 32'h40,   64'hDEADBEEF_CAFEF00D, 8'hFF, 2'b00, 64'h0};
        vecs[1] = '{1'b0, 4'h2, 32'h40,   64'h0,                 8'h00, 2'b00, 64'hDEADBEEF_CAFEF00D};
        vecs[2] = '{1'b1, 4'h3, 32'h200,  64'hFFFFFFFF_FFFFFFFF, 8'hFF, 2'b00, 64'h0};
        vecs[3] = '{1'b1, 4'h4, 32'h200,  64'h0,                 8'h0F, 2'b00, 64'h0};
        vecs[4] = '{1'b0, 4'h5, 32'h200,  64'h0,                 8'h00, 2'b00, 64'hFFFFFFFF_00000000};
        vecs[5] = '{1'b0, 4'h6, 32'h8000, 64'h0,                 8'h00, 2'b11, 64'h0};
        vecs[6] = '{1'b1, 4'h7, 32'h8000, 64'h0123456789ABCDEF,  8'hFF, 2'b11, 64'h0};
        vecs[7] = '{1'b0, 4'h8, 32'h7FF0, 64'h0,                 8'h00, 2'b00, 64'h0};
        vecs[8] = '{1'b1, 4'h9, 32'h7FF0, 64'h12345678_9ABCDEF0, 8'hF0, 2'b00, 64'h0};
        vecs[9] = '{1'b0, 4'hA, 32'h7FF0, 64'h0,                 8'h00, 2'b00, 64'h12345678_00000000};

        // Reset state
        repeat (3) @(negedge clock);
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clock);
        chk("awready_after_init", 64'(axi_awready), 64'd1);
        chk("arready_after_init", 64'(axi_arready), 64'd1);

        // Directed single-beat vectors
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) begin
                wbuf_data[0] = vecs[i].data;
                wbuf_strb[0] = vecs[i].strb;
                do_write(vecs[i].id, vecs[i].addr, 0, 1'b0, 1'b0, gid_w, gresp_w);
                void'(model_write(vecs[i].addr, 0, 1'b0));
                chk($sformatf("vec%0d_bresp", i), 64'(gresp_w), 64'(vecs[i].exp_resp));
                chk($sformatf("vec%0d_bid", i), 64'(gid_w), 64'(vecs[i].id));
                $display("vec%0d write addr=%08h bresp=%0d", i, vecs[i].addr, gresp_w);
            end else begin
                do_read(vecs[i].id, vecs[i].addr, 0, 0);
                chk($sformatf("vec%0d_rdata", i), rbuf_data[0], vecs[i].exp_rdata);
                chk($sformatf("vec%0d_rresp", i), 64'(rbuf_resp[0]), 64'(vecs[i].exp_resp));
                chk($sformatf("vec%0d_rlast", i), 64'(rbuf_last[0]), 64'd1);
                chk($sformatf("vec%0d_rid", i), 64'(rbuf_id[0]), 64'(vecs[i].id));
                $display("vec%0d read  addr=%08h rdata=%016h rresp=%0d", i, vecs[i].addr, rbuf_data[0], rbuf_resp[0]);
            end
        end

        // 4-beat write then 4-beat read with rready toggling every cycle
        for (int n = 0; n < 4; n++) begin
            wbuf_data[n] = 64'hA5A5_0000_0000_0000 | 64'(n + 1);
            wbuf_strb[n] = 8'hFF;
        end
        run_write(4'h3, 32'h100, 3, 1'b0, 1'b0);
        run_read(4'h4, 32'h100, 3, 1);
        chk("burst4_beat3_const", rbuf_data[3], 64'hA5A5_0000_0000_0004);

        // wlast asserted on the wrong beat: SLVERR, length still from awlen
        wbuf_data[0] = 64'h1111; wbuf_strb[0] = 8'hFF;
        wbuf_data[1] = 64'h2222; wbuf_strb[1] = 8'hFF;
        run_write(4'h2, 32'h180, 1, 1'b1, 1'b0);
        chk("slverr_const", 64'(axi_bresp), 64'd2);
        run_read(4'h2, 32'h180, 1, 0);

        // Burst that runs off the end of memory: first beat lands, second is DECERR
        wbuf_data[0] = 64'hCCCC_0001; wbuf_strb[0] = 8'hFF;
        wbuf_data[1] = 64'hCCCC_0002; wbuf_strb[1] = 8'hFF;
        run_write(4'h6, 32'h7FF8, 1, 1'b0, 1'b0);
        run_read(4'h7, 32'h7FF8, 1, 0);

        // Simultaneous AW and AR to different words
        wbuf_data[0] = 64'h6060_6060; wbuf_strb[0] = 8'hFF;
        run_write(4'h1, 32'h600, 0, 1'b0, 1'b0);
        wbuf_data[0] = 64'h5050_5050; wbuf_strb[0] = 8'hFF;
        fork
            do_write(4'h5, 32'h500, 0, 1'b0, 1'b0, gid_w, gresp_w);
            do_read(4'h9, 32'h600, 0, 0);
        join
        eresp = model_write(32'h500, 0, 1'b0);
        chk("dual_bid", 64'(gid_w), 64'h5);
        chk("dual_bresp", 64'(gresp_w), 64'(eresp));
        chk("dual_rid", 64'(rbuf_id[0]), 64'h9);
        chk("dual_rdata", rbuf_data[0], 64'h6060_6060);
        $display("dual  aw id=5 bresp=%0d, ar id=%0h rdata=%016h", gresp_w, rbuf_id[0], rbuf_data[0]);
        run_read(4'hC, 32'h500, 0, 0);

        // Reset during beat 2 of a 4-beat write
        @(negedge clock);
        axi_awvalid = 1'b1; axi_awid = 4'hA; axi_awaddr = 32'h300; axi_awlen = 8'd3;
        t = 0;
        while (!axi_awready && t < BUDGET) begin @(negedge clock); t++; end
        if (t >= BUDGET) timeout_fail("rst aw handshake");
        @(negedge clock);
        axi_awvalid = 1'b0;
        axi_wvalid = 1'b1; axi_wdata = 64'hBEEF_0000_0000_0001; axi_wstrb = 8'hFF; axi_wlast = 1'b0;
        t = 0;
        while (!axi_wready && t < BUDGET) begin @(negedge clock); t++; end
        if (t >= BUDGET) timeout_fail("rst w beat");
        @(negedge clock);
        axi_wdata = 64'hBEEF_0000_0000_0002;
        reset = 1'b1;
        @(negedge clock);
        chk_reset_outputs("midburst_reset");
        axi_wvalid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("awready_after_reset", 64'(axi_awready), 64'd1);
        axi_bready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            if (axi_bvalid) seen = 1'b1;
            @(negedge clock);
        end
        axi_bready = 1'b0;
        chk("no_bvalid_after_reset", 64'(seen), 64'd0);
        mem_model[96] = 64'hBEEF_0000_0000_0001;
        run_read(4'hB, 32'h300, 0, 0);
        $display("reset mid-burst: bvalid seen=%0d", seen);

        // Randomized bursts against the model
        for (int k = 0; k < 40; k++) begin
            logic [31:0] addr;
            int len;
            addr = 32'($urandom_range(128, 4100)) << 3;
            if ($urandom_range(0, 3) == 0) addr = addr | 32'($urandom_range(1, 7));
            len = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                for (int n = 0; n <= len; n++) begin
                    wbuf_data[n] = {$urandom, $urandom};
                    wbuf_strb[n] = 8'($urandom);
                end
                run_write(4'($urandom), addr, len, ($urandom_range(0, 5) == 0), 1'b1);
            end else begin
                run_read(4'($urandom), addr, len, 2);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/axi_sim_mem.md
AXI_SIM_MEM -- requirements
Module: axi_sim_mem

Interface
REQ-001 SHALL take parameter DATA_W, default 64, meaning AXI data width in bits (power of 2, 32..256).
REQ-002 SHALL take parameter ID_W, default 4, meaning AXI ID width.
REQ-003 SHALL take parameter DEPTH, default 4096, meaning memory size in DATA_W words (power of 2).
REQ-004 SHALL have `clock`, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have `reset`, input, 1, a synchronous active-high reset.
REQ-006 SHALL have `axi_awvalid`, input, 1, meaning write address valid.
REQ-007 SHALL have `axi_awready`, output, 1, meaning write address accepted.
REQ-008 SHALL have `axi_awid`, input, ID_W, meaning write transaction ID.
REQ-009 SHALL have `axi_awaddr`, input, 32, meaning write byte address.
REQ-010 SHALL have `axi_awlen`, input, 8, meaning write beats minus 1.
REQ-011 SHALL have `axi_wvalid`, input, 1, meaning write data valid.
REQ-012 SHALL have `axi_wready`, output, 1, meaning write data accepted.
REQ-013 SHALL have `axi_wdata`, input, DATA_W, meaning write data.
REQ-014 SHALL have `axi_wstrb`, input, DATA_W/8, meaning byte enables.
REQ-015 SHALL have `axi_wlast`, input, 1, meaning final write beat.
REQ-016 SHALL have `axi_bvalid`, output, 1, meaning write response valid.
REQ-017 SHALL have `axi_bready`, input, 1, meaning write response accepted.
REQ-018 SHALL have `axi_bid`, output, ID_W, meaning response ID (echoes awid).
REQ-019 SHALL have `axi_bresp`, output, 2, meaning write response code.
REQ-020 SHALL have `axi_arvalid`, input, 1, meaning read address valid.
REQ-021 SHALL have `axi_arready`, output, 1, meaning read address accepted.
REQ-022 SHALL have `axi_arid`, input, ID_W, meaning read transaction ID.
REQ-023 SHALL have `axi_araddr`, input, 32, meaning read byte address.
REQ-024 SHALL have `axi_arlen`, input, 8, meaning read beats minus 1.
REQ-025 SHALL have `axi_rvalid`, output, 1, meaning read data valid.
REQ-026 SHALL have `axi_rready`, input, 1, meaning read data accepted.
REQ-027 SHALL have `axi_rid`, output, ID_W, meaning read ID (echoes arid).
REQ-028 SHALL have `axi_rdata`, output, DATA_W, meaning read data.
REQ-029 SHALL have `axi_rresp`, output, 2, meaning read response code.
REQ-030 SHALL have `axi_rlast`, output, 1, meaning final read beat.

Function
REQ-031 SHALL support INCR bursts of full DATA_W beats only.
- Beat address = start + n*(DATA_W/8).
- Word index = address >> log2(DATA_W/8).
REQ-032 SHALL run independent write and read FSMs, each allowing one outstanding burst.
REQ-033 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP.
- W_IDLE: awready=1; an AW handshake latches id, addr and len, then goes to W_DATA.
- W_DATA: wready=1; each beat writes only the bytes enabled by wstrb.
- After beat awlen+1, goes to W_RESP.
- W_RESP: bvalid=1 until bready is sampled high, then back to W_IDLE.
REQ-034 Read FSM SHALL have states R_IDLE, R_FETCH and R_DATA.
- R_IDLE: arready=1; an AR handshake goes to R_FETCH.
- R_FETCH: registered 1-cycle memory read, then goes to R_DATA.
- R_DATA: rvalid=1, with rid, rdata, rresp and rlast held stable until rready is high.
- On each accepted beat: goes to R_FETCH for the next word, or back to R_IDLE after the last beat.
REQ-035 SHALL assert rlast exactly on beat arlen+1.
REQ-036 Any beat with word index >= DEPTH SHALL be DECERR (2'b11).
- Such a write is dropped.
- Such a read returns all-zero rdata.
REQ-037 A wlast value that disagrees with the beat count SHALL produce bresp SLVERR (2'b10); the burst length still follows awlen.
REQ-038 bresp SHALL be the worst code seen during the burst (DECERR > SLVERR > OKAY); rresp SHALL be per beat.
REQ-039 A read fetch and a write beat to the same word in the same cycle SHALL return the old data (read-before-write).
REQ-040 Simultaneous AW and AR handshakes SHALL both be accepted in the same cycle.

Reset
REQ-041 While reset=1 at a clock edge, the block SHALL:
- force both FSMs to their IDLE state;
- drive awready, wready, bvalid, arready and rvalid to 0;
- drive bid, bresp, rid, rdata, rresp and rlast to 0.
REQ-042 A reset mid-burst SHALL abandon the burst with no response issued; beats already written SHALL remain in memory.
REQ-043 Memory contents SHALL NOT be cleared by reset; they SHALL be zero at time 0.

Structure
REQ-044 Package axi_sim_pkg SHALL hold the response codes (OKAY, SLVERR, DECERR) and the FSM state enums.
REQ-045 Sub-module axi_sim_ram SHALL be a 1-write, 1-read port RAM with byte enables and a registered read.

Verification
REQ-046 The bench SHALL cover these directed scenarios:
- Single write of 0xDEADBEEF_CAFEF00D to address 0x40 with wstrb=0xFF, then a read of 0x40 -> bresp=0, rdata=0xDEADBEEF_CAFEF00D, rlast=1.
- 4-beat write (awlen=3) to 0x100, then 4-beat read with rready toggling every cycle -> data returned in order, rlast on beat 4 only, rdata stable while stalled.
- Write with wstrb=0x0F over a word holding 0xFFFFFFFF_FFFFFFFF, data 0 -> readback 0xFFFFFFFF_00000000.
- Read at word index DEPTH (byte address 0x8000 with default parameters) -> rresp=2'b11, rdata=0; a write to the same address -> bresp=2'b11.
- Reset asserted during beat 2 of a 4-beat write -> no bvalid afterwards, awready=1 one cycle after reset is released.
- AW and AR issued in the same cycle to different words -> both complete, each with its own ID echoed.
